// File: rtl/onchip_mem_dp_pipe.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports (A = s1, B = s2), byte enables and pipelined reads.
// Latency: an accepted read is captured at edge N; readdata/readdatavalid appear after edge N+READ_LATENCY (en edges).
// Backpressure: waitrequest = ~(clken & ~reset_req); with ONCHIP_MEM_CLEAR_EN it also stays high during the post-reset clear.
//
// Optional macro: ONCHIP_MEM_CLEAR_EN - zero-fill sweep of all DEPTH words after reset_n is released.
// Ports: clk, reset_n (sync, active-low), clken, reset_req (global enable terms);
//        a_* / b_*: chipselect, read, write, address, byteenable, writedata -> readdata, readdatavalid, waitrequest.
module onchip_mem_dp_pipe #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 64000,
    parameter int READ_LATENCY = 1,
    parameter int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              reset_req,
    input  logic              a_chipselect,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic [DATA_W-1:0] a_writedata,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    output logic              a_waitrequest,
    input  logic              b_chipselect,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic [DATA_W-1:0] b_writedata,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    output logic              b_waitrequest
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Stage 0 is the RAM read register, the remaining READ_LATENCY stages feed the ports.
    localparam int NST = READ_LATENCY + 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_en;
    logic w_busy;
    logic w_acc;
    assign w_en = clken & ~reset_req;

`ifdef ONCHIP_MEM_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} clr_state_t;
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);
    clr_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic             w_clr_we;

    // IDLE is the first sweep cycle (word 0), so the sweep occupies exactly DEPTH en-cycles.
    // Held in reset the ports report ready; the sweep only blocks them once reset_n is high.
    assign w_busy   = reset_n & (r_state != DONE);
    assign w_clr_we = w_busy & w_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else if (w_clr_we) begin
            r_ptr   <= r_ptr + IDX_W'(1);
            r_state <= (r_ptr == LAST_PTR) ? DONE : CLEAR;
        end
    end
`else
    assign w_busy = 1'b0;
`endif

    assign a_waitrequest = ~w_en | w_busy;
    assign b_waitrequest = ~w_en | w_busy;
    // Nothing is accepted while reset is asserted.
    assign w_acc = w_en & ~w_busy & reset_n;

    logic             w_a_inr, w_b_inr;
    logic [IDX_W-1:0] w_a_idx, w_b_idx;
    logic             w_a_wr, w_a_rd, w_b_wr, w_b_rd;
    logic [DATA_W-1:0] w_a_rdat, w_b_rdat;

    assign w_a_inr  = ({1'b0, a_address} < DEPTH_X);
    assign w_b_inr  = ({1'b0, b_address} < DEPTH_X);
    assign w_a_idx  = a_address[IDX_W-1:0];
    assign w_b_idx  = b_address[IDX_W-1:0];
    assign w_a_wr   = w_acc & a_chipselect & a_write & w_a_inr;
    assign w_b_wr   = w_acc & b_chipselect & b_write & w_b_inr;
    // Write wins over read on the same port; out-of-range reads still complete, returning zero.
    assign w_a_rd   = w_acc & a_chipselect & a_read & ~a_write;
    assign w_b_rd   = w_acc & b_chipselect & b_read & ~b_write;
    assign w_a_rdat = w_a_inr ? r_mem[w_a_idx] : '0;
    assign w_b_rdat = w_b_inr ? r_mem[w_b_idx] : '0;

    // Reads sample r_mem before this edge's writes land, so a cross-port read sees old data.
    // Port A is applied after port B, so A wins on lanes both ports enable.
    always_ff @(posedge clk) begin
`ifdef ONCHIP_MEM_CLEAR_EN
        if (w_clr_we) r_mem[r_ptr] <= '0;
`endif
        for (int i = 0; i < BE_W; i++) begin
            if (w_b_wr && b_byteenable[i]) r_mem[w_b_idx][i*8 +: 8] <= b_writedata[i*8 +: 8];
            if (w_a_wr && a_byteenable[i]) r_mem[w_a_idx][i*8 +: 8] <= a_writedata[i*8 +: 8];
        end
    end

    logic [DATA_W-1:0] r_a_dat [NST];
    logic [DATA_W-1:0] r_b_dat [NST];
    logic [NST-1:0]    r_a_vld;
    logic [NST-1:0]    r_b_vld;

    // Read pipelines advance only on en cycles, so a frozen bus holds data and valid in place.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_vld <= '0;
            r_b_vld <= '0;
            for (int i = 0; i < NST; i++) begin
                r_a_dat[i] <= '0;
                r_b_dat[i] <= '0;
            end
        end else if (w_en) begin
            r_a_vld    <= {r_a_vld[NST-2:0], w_a_rd};
            r_b_vld    <= {r_b_vld[NST-2:0], w_b_rd};
            r_a_dat[0] <= w_a_rdat;
            r_b_dat[0] <= w_b_rdat;
            for (int i = 1; i < NST; i++) begin
                r_a_dat[i] <= r_a_dat[i-1];
                r_b_dat[i] <= r_b_dat[i-1];
            end
        end
    end

    assign a_readdata      = r_a_dat[NST-1];
    assign a_readdatavalid = r_a_vld[NST-1];
    assign b_readdata      = r_b_dat[NST-1];
    assign b_readdatavalid = r_b_vld[NST-1];

endmodule

// File: doc/onchip_mem_dp_pipe.md
Name: onchip_mem_dp_pipe

Overview:
Parametrised successor to the single-port on-chip memory slave. It is a behavioural true dual-port RAM with two independent Avalon-MM slave ports, s1 (port A) and s2 (port B). Each port has byte enables, a configurable pipelined read latency with readdatavalid, and defined collision rules. It sits on the system interconnect as shared frame/coefficient storage between the CPU master and the DCT datapath master.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 16, word address width
DEPTH, 64000, number of words; must be <= 2**ADDR_W
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2
BE_W, DATA_W/8, byte-enable width (derived; do not override)

Ports:
clk  in  1  single clock for both ports
reset_n  in  1  synchronous reset, active-low
clken  in  1  global clock enable; low freezes all state
reset_req  in  1  high gates the clock enable, same as clken low
a_chipselect  in  1  port A select
a_read  in  1  port A read strobe
a_write  in  1  port A write strobe
a_address  in  ADDR_W  port A word address
a_byteenable  in  BE_W  port A byte lanes
a_writedata  in  DATA_W  port A write data
a_readdata  out  DATA_W  port A read data
a_readdatavalid  out  1  port A read data valid
a_waitrequest  out  1  port A stall
b_* (chipselect, read, write, address, byteenable, writedata, readdata, readdatavalid, waitrequest)  same widths and meaning for port B

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: readdata 0, readdatavalid 0, waitrequest 0, read pipelines flushed. RAM contents are not reset.
- Effective enable: en = clken & ~reset_req. While en is 0:
  - no access is accepted;
  - pipeline registers, readdata and readdatavalid hold their values;
  - waitrequest = 1 on both ports.
- Accept conditions, per port, when en=1 and waitrequest=0:
  - Write: chipselect & write. Each byte lane i is written when byteenable[i]=1.
  - Read: chipselect & read & ~write. Write has priority if both strobes are high.
- Read latency:
  - Readdata and readdatavalid are registered.
  - With READ_LATENCY=1, the read accepted at edge N has data and valid=1 after edge N+1.
  - With READ_LATENCY=2, one extra register stage is added.
  - Back-to-back reads give one result per cycle.
  - readdatavalid is high for exactly one cycle per accepted read.
- Out-of-range address (address >= DEPTH):
  - write is dropped;
  - read completes normally with readdata = 0.
- Same-port read-during-write cannot happen (write has priority).
- Cross-port read/write to the same address in the same cycle: the read returns the old data.
- Both ports write the same address in the same cycle:
  - on lanes enabled on both ports, port A wins;
  - on lanes enabled on only one port, that port's byte is written.
- A reset during an outstanding read discards it. No readdatavalid is issued after reset.

Optional Feature:
Macro: ONCHIP_MEM_CLEAR_EN
- With the macro defined: a clear FSM (IDLE, CLEAR, DONE) starts when reset_n is released.
  - CLEAR writes 0 to word ptr, ptr increments 0 to DEPTH-1, one word per en=1 cycle.
  - During CLEAR, waitrequest = 1 on both ports.
  - After the last word, the FSM goes to DONE and waitrequest drops.
  - Total clear time is DEPTH en-cycles.
  - Reset asserted mid-CLEAR restarts the sweep from ptr=0 on release.
- Without the macro: there is no FSM, contents after power-up are undefined, and waitrequest only reflects en.

Test Plan:
- Port A writes 0xDEADBEEF to addr 5 with be=4'b1111, then a port B read of addr 5 -> b_readdata=0xDEADBEEF with valid exactly 1 cycle after acceptance (READ_LATENCY=1), 2 cycles (READ_LATENCY=2).
- Partial write: addr 7 holds 0x11223344; A writes 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- Collision: A writes 0x000000FF with be=4'b0011 and B writes 0xFFFF0000 with be=4'b1110 to addr 9 in the same cycle -> addr 9 = 0xFFFF00FF.
- Cross-port: addr 3 holds 0x1; A writes 0x2 while B reads addr 3 in the same cycle -> B gets 0x1; the next B read of addr 3 gets 0x2.
- Out of range and enable: read of addr DEPTH -> readdata 0 with valid 1. With clken=0 mid-burst, waitrequest=1 and valid held; the burst resumes intact when clken returns to 1.
- With ONCHIP_MEM_CLEAR_EN, DEPTH=16: after reset release, waitrequest=1 for 16 cycles, then all 16 words read 0. reset_n pulsed at cycle 8 -> the sweep restarts and takes 16 more cycles.
